// File: rtl/rpn_tokenizer.sv
// rpn_tokenizer: ASCII reverse-Polish character stream to calculator command converter.
// Digits accumulate into an 8-bit operand, delimiters/operators issue push and op commands.
// Optional feature macro: RPN_TOKENIZER_POP_EN makes '.' the pop character (op 1);
// without it '.' is an illegal character.

module rpn_tokenizer #(
    parameter int unsigned MAX_DIGITS = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] char_data,
    input  logic       char_valid,
    output logic       char_ready,
    output logic [7:0] calc_in,
    output logic [2:0] calc_op,
    output logic       calc_apply,
    input  logic       calc_valid,
    output logic       err,
    output logic       idle
);

    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

    typedef enum logic [1:0] {
        st_idle,
        st_num,
        st_opq,
        st_error
    } state_t;

    state_t           state;
    logic [7:0]       acc;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;

    logic       is_digit;
    logic       is_delim;
    logic       is_op;
    logic [2:0] op_code;
    logic [3:0] digit;
    logic [11:0] acc_ext;
    logic       accept;

    // Character classification and the widened decimal accumulate.
    always_comb begin
        digit    = char_data[3:0];
        is_digit = (char_data >= 8'h30) && (char_data <= 8'h39);
        is_delim = (char_data == 8'h20) || (char_data == 8'h0d) || (char_data == 8'h0a);
        is_op    = 1'b1;
        op_code  = 3'd0;
        case (char_data)
            8'h2b:   op_code = 3'd2;  // '+'
            8'h2a:   op_code = 3'd3;  // '*'
            8'h2d:   op_code = 3'd4;  // '-'
            8'h2f:   op_code = 3'd5;  // '/'
            8'h25:   op_code = 3'd6;  // '%'
`ifdef RPN_TOKENIZER_POP_EN
            8'h2e:   op_code = 3'd1;  // '.'
`endif
            default: is_op = 1'b0;
        endcase
        acc_ext = {4'd0, acc} * 12'd10 + {8'd0, digit};
    end

    // Handshake and status outputs; only the operator-pending state stalls the source.
    always_comb begin
        char_ready = (state != st_opq);
        accept     = char_valid && char_ready;
        idle       = (state == st_idle) && !calc_apply;
    end

    // Tokenizer state machine with registered command outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= st_idle;
            acc        <= 8'd0;
            cnt        <= '0;
            op_q       <= 3'd0;
            calc_apply <= 1'b0;
            calc_op    <= 3'd0;
            calc_in    <= 8'd0;
            err        <= 1'b0;
        end else begin
            calc_apply <= 1'b0;
            if (!calc_valid) begin
                // Calculator rejected a command: abandon everything, including a pending op.
                state <= st_error;
                err   <= 1'b1;
            end else begin
                case (state)
                    st_idle: begin
                        if (accept) begin
                            if (is_digit) begin
                                state <= st_num;
                                acc   <= {4'd0, digit};
                                cnt   <= CNT_W'(1);
                            end else if (is_op) begin
                                calc_apply <= 1'b1;
                                calc_op    <= op_code;
                            end else if (!is_delim) begin
                                state <= st_error;
                                err   <= 1'b1;
                            end
                        end
                    end
                    st_num: begin
                        if (accept) begin
                            if (is_digit) begin
                                if ((cnt >= CNT_MAX) || (acc_ext > 12'd255)) begin
                                    state <= st_error;
                                    err   <= 1'b1;
                                end else begin
                                    acc <= acc_ext[7:0];
                                    cnt <= cnt + 1'b1;
                                end
                            end else if (is_delim || is_op) begin
                                calc_apply <= 1'b1;
                                calc_op    <= 3'd0;
                                calc_in    <= acc;
                                acc        <= 8'd0;
                                cnt        <= '0;
                                op_q       <= op_code;
                                state      <= is_op ? st_opq : st_idle;
                            end else begin
                                state <= st_error;
                                err   <= 1'b1;
                            end
                        end
                    end
                    st_opq: begin
                        calc_apply <= 1'b1;
                        calc_op    <= op_q;
                        state      <= st_idle;
                    end
                    st_error: begin
                        // Sink: characters are consumed and dropped until reset.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rpn_tokenizer.sv
// Directed bench for rpn_tokenizer with a small stack-calculator model on the command side.

module tb_rpn_tokenizer;

    logic       clk;
    logic       reset_n;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic [7:0] calc_in;
    logic [2:0] calc_op;
    logic       calc_apply;
    logic       calc_valid;
    logic       err;
    logic       idle;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;

    logic [10:0] log_cmd[$];
    int          log_cyc[$];
    logic [10:0] exp_q[$];

    // Calculator model: result = top OP next, pops two and pushes one.
    logic [7:0] stk[16];
    logic [3:0] sp;
    logic       bad;

    rpn_tokenizer #(.MAX_DIGITS(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .calc_in    (calc_in),
        .calc_op    (calc_op),
        .calc_apply (calc_apply),
        .calc_valid (calc_valid),
        .err        (err),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign calc_valid = !bad;

    function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] t,
                                       input logic [7:0] n);
        case (op)
            3'd2:    return t + n;
            3'd3:    return t * n;
            3'd4:    return t - n;
            3'd5:    return t / n;
            3'd6:    return t % n;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [10:0] cmd(input logic [2:0] op, input logic [7:0] val);
        return {op, val};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp  <= 4'd0;
            bad <= 1'b0;
        end else if (calc_apply) begin
            if (calc_op == 3'd0) begin
                stk[sp] <= calc_in;
                sp      <= sp + 4'd1;
            end else if (calc_op == 3'd1) begin
                if (sp < 4'd1) bad <= 1'b1;
                else sp <= sp - 4'd1;
            end else if (sp < 4'd2) begin
                bad <= 1'b1;
            end else if ((calc_op == 3'd5 || calc_op == 3'd6) && stk[sp-4'd2] == 8'd0) begin
                bad <= 1'b1;
            end else begin
                stk[sp-4'd2] <= alu(calc_op, stk[sp-4'd1], stk[sp-4'd2]);
                sp           <= sp - 4'd1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (calc_apply) begin
            log_cmd.push_back({calc_op, calc_in});
            log_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        char_valid = 1'b0;
        char_data  = 8'h00;
        reset_n    = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        log_cmd.delete();
        log_cyc.delete();
        exp_q.delete();
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_char(input logic [7:0] c);
        int guard;
        guard      = 0;
        char_data  = c;
        char_valid = 1'b1;
        while (!char_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_ncmd"}, log_cmd.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_cmd.size(); i++)
            check($sformatf("%s_cmd%0d", tag, i), {21'd0, log_cmd[i]}, {21'd0, exp_q[i]});
    endtask

    initial begin
        int n_op2;
        reset_n    = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;
        #3;
        check("rst_ready", char_ready, 1);
        check("rst_apply", calc_apply, 0);
        check("rst_op",    calc_op,    0);
        check("rst_in",    calc_in,    0);
        check("rst_err",   err,        0);
        check("rst_idle",  idle,       1);

        // "4 4 +\n"
        do_reset();
        send_str("4 4 ");
        check("t1_idle_during_push", idle, 0);
        send_str("+\n");
        repeat (3) @(negedge clk);
        exp_q = '{cmd(3'd0, 8'd4), cmd(3'd0, 8'd4), cmd(3'd2, 8'd4)};
        check_log("t1");
        check("t1_tail",  stk[sp-4'd1], 8);
        check("t1_depth", sp, 1);
        check("t1_err",   err, 0);
        check("t1_idle",  idle, 1);

        // "7 86/" with a character offered during the operator bubble
        do_reset();
        send_str("7 86/");
        check("t2_ready_bubble", char_ready, 0);
        check("t2_push86_now", {calc_apply, calc_op, calc_in}, {1'b1, 3'd0, 8'd86});
        send_char(8'h20);
        check("t2_ready_after", char_ready, 1);
        repeat (3) @(negedge clk);
        exp_q = '{cmd(3'd0, 8'd7), cmd(3'd0, 8'd86), cmd(3'd5, 8'd86)};
        check_log("t2");
        if (log_cyc.size() == 3) check("t2_consecutive", log_cyc[2] - log_cyc[1], 1);
        check("t2_tail", stk[sp-4'd1], 12);
        check("t2_err", err, 0);

        // "255 256 " overflow on the last digit
        do_reset();
        send_str("255 25");
        check("t3_err_before", err, 0);
        send_char("6");
        check("t3_err", err, 1);
        check("t3_idle", idle, 0);
        check("t3_ready", char_ready, 1);
        send_str(" 1 +");
        repeat (3) @(negedge clk);
        exp_q = '{cmd(3'd0, 8'd255)};
        check_log("t3");
        check("t3_err_sticky", err, 1);

        // "0 86%" calculator reports invalid (86 mod 0)
        do_reset();
        send_str("0 86%");
        @(negedge clk);
        @(negedge clk);
        check("t4_valid_low", calc_valid, 0);
        check("t4_err_not_yet", err, 0);
        @(negedge clk);
        check("t4_err", err, 1);
        send_str("1 ");
        repeat (3) @(negedge clk);
        exp_q = '{cmd(3'd0, 8'd0), cmd(3'd0, 8'd86), cmd(3'd6, 8'd86)};
        check_log("t4");

        // "0007 " exceeds three digits
        do_reset();
        send_str("000");
        check("t5_three_ok", err, 0);
        send_str("7 ");
        repeat (2) @(negedge clk);
        check("t5_err", err, 1);
        check("t5_ncmd", log_cmd.size(), 0);

        // Illegal character after digits: no push
        do_reset();
        send_str("12x ");
        repeat (2) @(negedge clk);
        check("t6_err", err, 1);
        check("t6_ncmd", log_cmd.size(), 0);

        // Reset during the operator-pending cycle of "9+"
        do_reset();
        send_str("9+");
        #2;
        reset_n = 1'b0;
        #1;
        check("t7_apply", calc_apply, 0);
        check("t7_ready", char_ready, 1);
        check("t7_op",    calc_op, 0);
        check("t7_in",    calc_in, 0);
        check("t7_err",   err, 0);
        check("t7_idle",  idle, 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        n_op2 = 0;
        foreach (log_cmd[i]) if (log_cmd[i][10:8] == 3'd2) n_op2++;
        check("t7_no_op2", n_op2, 0);

        // '.' after "5 "
        do_reset();
        send_str("5 .");
        repeat (3) @(negedge clk);
`ifdef RPN_TOKENIZER_POP_EN
        exp_q = '{cmd(3'd0, 8'd5), cmd(3'd1, 8'd5)};
        check_log("t8");
        check("t8_empty", sp, 0);
        check("t8_err", err, 0);
`else
        exp_q = '{cmd(3'd0, 8'd5)};
        check_log("t8");
        check("t8_err", err, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
